// File: rtl/melody_game_core_pkg.sv
// Shared types and constants for the melody memory game core.
package melody_game_core_pkg;

  // Top-level game FSM states.
  typedef enum logic [2:0] {
    IDLE,
    PLAY_ON,
    PLAY_OFF,
    WAIT_KEY,
    ECHO,
    WIN,
    LOSE
  } state_t;

  // Where the FSM goes once a key echo has finished.
  typedef enum logic [1:0] {
    AFTER_WAIT,
    AFTER_PLAY,
    AFTER_WIN,
    AFTER_LOSE
  } after_t;

  // Note code that means "no sound, LED off".
  localparam int NOTE_SILENT = 0;

endpackage

// File: rtl/melody_game_core_if.sv
// Player-facing bus of the melody game: pattern/key inputs, sound/LED/status outputs.
interface melody_game_core_if #(
  parameter int NOTE_W    = 4,
  parameter int MAX_NOTES = 8,
  parameter int LIVES     = 3
);
  localparam int LVL_W = $clog2(MAX_NOTES + 1);
  localparam int LIV_W = $clog2(LIVES + 1);

  logic [MAX_NOTES*NOTE_W-1:0] pattern_in;
  logic                        pattern_load;
  logic                        start;
  logic                        key_valid;
  logic [NOTE_W-1:0]           key_code;
  logic [NOTE_W-1:0]           tone_out;
  logic [NOTE_W-1:0]           led_out;
  logic                        busy;
  logic [LVL_W-1:0]            level_out;
  logic [LIV_W-1:0]            lives_out;
  logic                        miss_pulse;
  logic                        game_win;
  logic                        game_over;

  // Drives the game (player / host side).
  modport master (
    output pattern_in, pattern_load, start, key_valid, key_code,
    input  tone_out, led_out, busy, level_out, lives_out,
    input  miss_pulse, game_win, game_over
  );

  // The game core itself.
  modport slave (
    input  pattern_in, pattern_load, start, key_valid, key_code,
    output tone_out, led_out, busy, level_out, lives_out,
    output miss_pulse, game_win, game_over
  );

endinterface

// File: rtl/melody_game_core_tick_gen.sv
// Free-running prescaler: tick is high for one clk in every DIV clks.
module tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..DIV-1 and wrap; the tick marks the wrap cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset)              r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/melody_game_core.sv
// Melody memory game: plays a growing note pattern, then checks the player's echo.
module melody_game_core
  import melody_game_core_pkg::*;
#(
  parameter int NOTE_W        = 4,
  parameter int MAX_NOTES     = 8,
  parameter int START_LEN     = 3,
  parameter int TICK_DIV      = 5000000,
  parameter int ON_TICKS      = 2,
  parameter int OFF_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 20,
  parameter int LIVES         = 3
) (
  input logic               clk,
  input logic               reset,
  melody_game_core_if.slave bus
);
  localparam int PW = MAX_NOTES * NOTE_W;
  localparam int IW = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
  localparam int LW = $clog2(MAX_NOTES + 1);
  localparam int VW = $clog2(LIVES + 1);
  localparam int MAX_OO = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_T  = (TIMEOUT_TICKS > MAX_OO) ? TIMEOUT_TICKS : MAX_OO;
  localparam int CW = $clog2(MAX_T + 1);

  localparam logic [LW-1:0]     START_LVL = LW'(START_LEN);
  localparam logic [LW-1:0]     MAX_LVL   = LW'(MAX_NOTES);
  localparam logic [VW-1:0]     FULL_LIV  = VW'(LIVES);
  localparam logic [CW-1:0]     ON_LAST   = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0]     OFF_LAST  = CW'(OFF_TICKS - 1);
  localparam logic [CW-1:0]     TO_LAST   = CW'(TIMEOUT_TICKS - 1);
  localparam logic [NOTE_W-1:0] SILENT    = NOTE_W'(NOTE_SILENT);

  function automatic logic [NOTE_W-1:0] note_at(input logic [PW-1:0] pat,
                                                input logic [IW-1:0] i);
    note_at = pat[i*NOTE_W +: NOTE_W];
  endfunction

  state_t            r_state;
  after_t            r_after;
  logic              r_loaded;
  logic [PW-1:0]     r_shadow;   // last loaded pattern, applied at start
  logic [PW-1:0]     r_pattern;  // pattern of the game in progress
  logic [LW-1:0]     r_level;
  logic [VW-1:0]     r_lives;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_tcnt;
  logic [NOTE_W-1:0] r_note;
  logic              r_busy, r_miss, r_win, r_over;

  logic              w_tick, w_last, w_key_ok, w_restart, w_lives_low;
  logic [NOTE_W-1:0] w_note;
  logic [PW-1:0]     w_start_pat;

  tick_gen #(.DIV(TICK_DIV)) u_tick (.clk(clk), .reset(reset), .tick(w_tick));

  assign w_note      = note_at(r_pattern, r_idx);
  assign w_last      = (LW'(r_idx) == r_level - LW'(1));
  assign w_key_ok    = (bus.key_code == w_note);
  assign w_lives_low = (r_lives <= VW'(1));
  assign w_start_pat = bus.pattern_load ? bus.pattern_in : r_shadow;
  assign w_restart   = bus.start && ((r_state == IDLE && r_loaded) ||
                                     r_state == WIN || r_state == LOSE);

  // Game FSM with registered outputs; every state change clears the tick counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the pattern registers are plain flops, not a RAM, so clearing
      // them in reset is cheap and gives a known silent pattern.
      r_state   <= IDLE;
      r_after   <= AFTER_WAIT;
      r_loaded  <= 1'b0;
      r_shadow  <= '0;
      r_pattern <= '0;
      r_level   <= '0;
      r_lives   <= '0;
      r_idx     <= '0;
      r_tcnt    <= '0;
      r_note    <= SILENT;
      r_busy    <= 1'b0;
      r_miss    <= 1'b0;
      r_win     <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_miss <= 1'b0;
      if (w_tick) r_tcnt <= r_tcnt + CW'(1);
      if (bus.pattern_load) r_shadow <= bus.pattern_in;
      if (bus.pattern_load && r_state == IDLE) r_loaded <= 1'b1;

      if (w_restart) begin
        r_pattern <= w_start_pat;
        r_level   <= START_LVL;
        r_lives   <= FULL_LIV;
        r_idx     <= '0;
        r_tcnt    <= '0;
        r_note    <= w_start_pat[NOTE_W-1:0];
        r_busy    <= 1'b1;
        r_win     <= 1'b0;
        r_over    <= 1'b0;
        r_state   <= PLAY_ON;
      end else begin
        case (r_state)
          PLAY_ON: if (w_tick && r_tcnt == ON_LAST) begin
            r_tcnt  <= '0;
            r_note  <= SILENT;
            r_state <= PLAY_OFF;
          end
          PLAY_OFF: if (w_tick && r_tcnt == OFF_LAST) begin
            r_tcnt <= '0;
            if (w_last) begin
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_state <= WAIT_KEY;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_note  <= note_at(r_pattern, r_idx + IW'(1));
              r_state <= PLAY_ON;
            end
          end
          WAIT_KEY: begin
            if (bus.key_valid) begin
              // A key always wins over a coincident timeout.
              r_tcnt  <= '0;
              r_note  <= bus.key_code;
              r_state <= ECHO;
              if (w_key_ok) begin
                if (!w_last) begin
                  r_idx   <= r_idx + IW'(1);
                  r_after <= AFTER_WAIT;
                end else if (r_level != MAX_LVL) begin
                  r_level <= r_level + LW'(1);
                  r_idx   <= '0;
                  r_after <= AFTER_PLAY;
                end else begin
                  r_after <= AFTER_WIN;
                end
              end else begin
                r_miss  <= 1'b1;
                r_lives <= (r_lives != '0) ? r_lives - VW'(1) : '0;
                r_idx   <= '0;
                r_after <= w_lives_low ? AFTER_LOSE : AFTER_PLAY;
              end
            end else if (w_tick && r_tcnt == TO_LAST) begin
              r_tcnt  <= '0;
              r_miss  <= 1'b1;
              r_lives <= (r_lives != '0) ? r_lives - VW'(1) : '0;
              r_idx   <= '0;
              if (w_lives_low) begin
                r_over  <= 1'b1;
                r_state <= LOSE;
              end else begin
                r_note  <= note_at(r_pattern, '0);
                r_busy  <= 1'b1;
                r_state <= PLAY_ON;
              end
            end
          end
          ECHO: if (w_tick && r_tcnt == ON_LAST) begin
            r_tcnt <= '0;
            r_note <= SILENT;
            case (r_after)
              AFTER_WAIT: r_state <= WAIT_KEY;
              AFTER_PLAY: begin
                r_note  <= w_note;
                r_busy  <= 1'b1;
                r_state <= PLAY_ON;
              end
              AFTER_WIN: begin
                r_win   <= 1'b1;
                r_state <= WIN;
              end
              default: begin
                r_over  <= 1'b1;
                r_state <= LOSE;
              end
            endcase
          end
          IDLE, WIN, LOSE: ;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.tone_out   = r_note;
  assign bus.led_out    = r_note;
  assign bus.busy       = r_busy;
  assign bus.level_out  = r_level;
  assign bus.lives_out  = r_lives;
  assign bus.miss_pulse = r_miss;
  assign bus.game_win   = r_win;
  assign bus.game_over  = r_over;

endmodule

// File: tb/tb_melody_game_core.sv
// Directed, table-driven bench for melody_game_core (TICK_DIV=1, pattern 1..8).
module tb_melody_game_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  melody_game_core_if #(.NOTE_W(4), .MAX_NOTES(8), .LIVES(3)) bus ();

  melody_game_core #(
    .NOTE_W(4), .MAX_NOTES(8), .START_LEN(3), .TICK_DIV(1),
    .ON_TICKS(2), .OFF_TICKS(2), .TIMEOUT_TICKS(20), .LIVES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int key;
    int miss;
    int level;
    int lives;
    int replay;  // notes expected in the following replay, 0 = none
  } key_vec_t;

  key_vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input int tone, input int busy,
                            input int level, input int lives, input int miss,
                            input int win, input int over);
    check({name, ".tone"},  int'(bus.tone_out),   tone);
    check({name, ".led"},   int'(bus.led_out),    tone);
    check({name, ".busy"},  int'(bus.busy),       busy);
    check({name, ".level"}, int'(bus.level_out),  level);
    check({name, ".lives"}, int'(bus.lives_out),  lives);
    check({name, ".miss"},  int'(bus.miss_pulse), miss);
    check({name, ".win"},   int'(bus.game_win),   win);
    check({name, ".over"},  int'(bus.game_over),  over);
  endtask

  // All stimulus tasks are entered and left at a falling edge.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Record one playback; expect notes 1..len, 2 cycles on and 2 cycles off each.
  task automatic capture(input string name, input int len);
    int tones[$];
    int bad = 0;
    int waited = 0;
    while (bus.busy !== 1'b1 && waited < 100) begin
      @(negedge clk);
      bus.key_valid = 1'b0;
      waited++;
    end
    check({name, ".busy_rise"}, int'(bus.busy), 1);
    while (bus.busy === 1'b1 && tones.size() < 200) begin
      tones.push_back(int'(bus.tone_out));
      if (bus.led_out !== bus.tone_out) bad++;
      @(negedge clk);
      bus.key_valid = 1'b0;
    end
    check({name, ".busy_cycles"}, tones.size(), 4 * len);
    for (int i = 0; i < tones.size(); i++) begin
      if (tones[i] != (((i % 4) < 2) ? (i / 4 + 1) : 0)) bad++;
    end
    check({name, ".note_errs"}, bad, 0);
  endtask

  // Press a key in WAIT_KEY; returns after the 2-cycle echo has finished.
  task automatic press(input int key, output int echo, output int miss, output int miss2);
    bus.key_code  = 4'(key);
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    echo = int'(bus.tone_out);
    miss = int'(bus.miss_pulse);
    @(negedge clk);
    miss2 = int'(bus.miss_pulse);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int echo, m1, m2, n, early;
    string tag;

    // Stimulus table: level 3 with one wrong key, then levels 3..8 played out.
    vecs.push_back('{1, 0, 3, 3, 0});
    vecs.push_back('{5, 1, 3, 2, 3});
    vecs.push_back('{1, 0, 3, 2, 0});
    vecs.push_back('{2, 0, 3, 2, 0});
    vecs.push_back('{3, 0, 4, 2, 4});
    for (int lvl = 4; lvl <= 8; lvl++) begin
      for (int k = 1; k <= lvl; k++) begin
        if (k == lvl && lvl < 8) vecs.push_back('{k, 0, lvl + 1, 2, lvl + 1});
        else                     vecs.push_back('{k, 0, lvl, 2, 0});
      end
    end

    bus.pattern_in   = '0;
    bus.pattern_load = 1'b0;
    bus.start        = 1'b0;
    bus.key_valid    = 1'b0;
    bus.key_code     = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0);

    // Start with nothing loaded stays in IDLE.
    pulse_start();
    repeat (3) @(negedge clk);
    check_outs("start_unloaded", 0, 0, 0, 0, 0, 0, 0);

    // Load and play level 1 (three notes, 12 busy cycles).
    bus.pattern_in   = 32'h8765_4321;
    bus.pattern_load = 1'b1;
    @(negedge clk);
    bus.pattern_load = 1'b0;
    pulse_start();
    check("first.level", int'(bus.level_out), 3);
    check("first.lives", int'(bus.lives_out), 3);
    capture("first_play", 3);

    // Table-driven key presses through to the win.
    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      press(vecs[i].key, echo, m1, m2);
      check({tag, ".echo"},  echo, vecs[i].key);
      check({tag, ".miss"},  m1, vecs[i].miss);
      check({tag, ".miss2"}, m2, 0);
      check({tag, ".level"}, int'(bus.level_out), vecs[i].level);
      check({tag, ".lives"}, int'(bus.lives_out), vecs[i].lives);
      if (vecs[i].replay > 0) capture({tag, "_replay"}, vecs[i].replay);
    end
    check_outs("win", 0, 0, 8, 2, 0, 1, 0);

    // Restart from WIN; a key during PLAY_ON must be ignored.
    pulse_start();
    check_outs("restart_win", 1, 1, 3, 3, 0, 0, 0);
    bus.key_code  = 4'd5;
    bus.key_valid = 1'b1;
    capture("key_in_play", 3);
    check("key_in_play.lives", int'(bus.lives_out), 3);

    // Key arriving on the same cycle the timeout expires counts as a key.
    early = 0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      early += int'(bus.miss_pulse);
    end
    check("coincide.early_miss", early, 0);
    press(1, echo, m1, m2);
    check("coincide.echo", echo, 1);
    check("coincide.miss", m1, 0);
    check("coincide.lives", int'(bus.lives_out), 3);

    // Three timeouts of 20 cycles each end the game.
    for (int t = 1; t <= 3; t++) begin
      tag = $sformatf("timeout%0d", t);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.miss_pulse !== 1'b1 && n < 40);
      check({tag, ".cycles"}, n, 20);
      check({tag, ".lives"}, int'(bus.lives_out), 3 - t);
      if (t < 3) capture({tag, "_replay"}, 3);
    end
    @(negedge clk);
    check_outs("lose", 0, 0, 3, 0, 0, 0, 1);

    // Restart from LOSE.
    pulse_start();
    check_outs("restart_lose", 1, 1, 3, 3, 0, 0, 0);

    // Reset in the middle of PLAY_ON silences everything on the next edge.
    reset = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_outs("reset_mid", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    repeat (3) @(negedge clk);
    check_outs("post_reset_start", 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/melody_game_core.md
MELODY_GAME_CORE -- requirements
Module: melody_game_core

Interface
REQ-001 SHALL have parameter NOTE_W, default 4, meaning bits per note code; code 0 means silence.
REQ-002 SHALL have parameter MAX_NOTES, default 8, meaning pattern depth; final level plays MAX_NOTES notes.
REQ-003 SHALL have parameter START_LEN, default 3, meaning notes played at level 1 (1..MAX_NOTES).
REQ-004 SHALL have parameter TICK_DIV, default 5000000, meaning clk cycles per tick (>=1).
REQ-005 SHALL have parameters ON_TICKS, default 2, and OFF_TICKS, default 2, meaning playback note-on and gap durations in ticks (>=1).
REQ-006 SHALL have parameter TIMEOUT_TICKS, default 20, meaning maximum ticks allowed per keypress before a miss.
REQ-007 SHALL have parameter LIVES, default 3, meaning misses tolerated before game over (>=1).
REQ-008 Ports, one per line: clk in 1 system clock; reset in 1 synchronous active-high reset; one clock, with reset synchronous and active-high.
REQ-009 pattern_in in MAX_NOTES*NOTE_W, with note i at bits [i*NOTE_W +: NOTE_W]; pattern_load in 1 one-cycle strobe.
REQ-010 start in 1 one-cycle strobe; key_valid in 1 one-cycle press strobe; key_code in NOTE_W pressed note.
REQ-011 tone_out out NOTE_W piezo note; led_out out NOTE_W LED note; busy out 1 playback in progress.
REQ-012 level_out out clog2(MAX_NOTES+1) current sequence length; lives_out out clog2(LIVES+1); miss_pulse out 1; game_win out 1; game_over out 1.

Function
REQ-013 SHALL implement FSM states IDLE, PLAY_ON, PLAY_OFF, WAIT_KEY, ECHO, WIN, LOSE.
REQ-014 Tick prescaler SHALL free-run from reset, asserting tick one cycle in every TICK_DIV; each state entry SHALL clear a per-state tick counter.
REQ-015 pattern_load SHALL latch pattern_in in any state; from IDLE only, it SHALL set the loaded flag; a load outside IDLE SHALL take effect at the next start.
REQ-016 start in IDLE with loaded=1 SHALL go to PLAY_ON next cycle with level=START_LEN, lives=LIVES, idx=0; start without loaded, or outside IDLE/WIN/LOSE, SHALL be ignored.
REQ-017 start in WIN or LOSE SHALL restart as REQ-016 and clear game_win/game_over.
REQ-018 PLAY_ON SHALL drive tone_out=led_out=note[idx] for ON_TICKS ticks, then enter PLAY_OFF with outputs 0.
REQ-019 PLAY_OFF after OFF_TICKS ticks: if idx==level-1, enter WAIT_KEY with idx=0; otherwise increment idx and enter PLAY_ON.
REQ-020 busy SHALL be 1 exactly in PLAY_ON and PLAY_OFF; key_valid SHALL be ignored while busy, in IDLE, in WIN/LOSE, and in ECHO.
REQ-021 In WAIT_KEY, key_valid SHALL be evaluated in the same cycle: the key is echoed on tone_out/led_out for ON_TICKS ticks in ECHO, then the FSM returns to WAIT_KEY.
REQ-022 Correct key with idx<level-1 SHALL increment idx; correct key with idx==level-1 and level<MAX_NOTES SHALL increment level and set idx=0, with replay (PLAY_ON) after ECHO.
REQ-023 Correct key with idx==level-1 and level==MAX_NOTES SHALL enter WIN after ECHO, set game_win=1, and keep it until restart or reset.
REQ-024 Wrong key, or TIMEOUT_TICKS ticks in WAIT_KEY without key_valid, SHALL pulse miss_pulse one cycle and decrement lives.
REQ-025 After a miss: if lives reaches 0, enter LOSE with game_over=1; otherwise set idx=0 and replay the same level from PLAY_ON, entered after ECHO for a wrong key and immediately for a timeout.
REQ-026 key_valid and timeout expiring in the same cycle SHALL be treated as a key press, not a timeout.
REQ-027 lives and level SHALL saturate and never wrap; all index arithmetic SHALL use clog2(MAX_NOTES) bits.

Reset
REQ-028 reset SHALL force IDLE, loaded=0, pattern=0, level=0, lives=0, idx=0, prescaler=0, and drive tone_out, led_out, busy, miss_pulse, game_win and game_over to 0.
REQ-029 reset SHALL take priority over all strobes in the same cycle, and reset mid-playback SHALL silence outputs on the next edge.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the note-code constants (NOTE_SILENT=0).
REQ-031 The tick prescaler SHALL be a separate sub-module tick_gen (parameter DIV; ports clk, reset, tick).

Verification
REQ-032 TICK_DIV=1, load 0x87654321, start -> tone_out sequence 1,2,3, each lasting 2 ticks with 2-tick gaps, busy high for 12 cycles, then WAIT_KEY.
REQ-033 Keys 1,2,3 -> level_out=4 and replay plays 1,2,3,4; keys 1..8 at level 8 -> game_win=1.
REQ-034 At level 3, key 1 then key 5 -> one miss_pulse, lives_out 3->2, replay from note 1.
REQ-035 Three consecutive timeouts of 20 ticks each -> three miss_pulses, then game_over=1, state LOSE, and start restarts with lives_out=3.
REQ-036 key_valid during PLAY_ON -> ignored (idx unchanged, no echo); key_valid coincident with the timeout tick -> evaluated as a key.
REQ-037 reset asserted mid-PLAY_ON -> next cycle all outputs 0, and start without pattern_load -> stays in IDLE.
